rd_ctrl_transpose: RTL

- Read controller on the read side of the frame RAM that wr_ctrl fills in row-major order (addr = r*CLO + c).
- On an rd_command pulse it reads the frame back column-major (transposed): for each column c, rows r = 0..ROW-1.
- It absorbs the RAM read latency and streams words downstream over a valid/ready handshake with full backpressure support.

---
 rtl/rd_ctrl_transpose_if.sv | 49 ++++
 rtl/rd_ctrl_transpose.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/rd_ctrl_transpose_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface : rd_ctrl_transpose_if                                         |
// | Purpose   : Bundles the command, RAM read port and output stream of the  |
// |             transposing read controller.                                 |
// | Modports  : master - the controller (drives rd_en/rd_addr/data_out...)   |
// |             slave  - the environment (drives rd_command/rd_data/ready)   |
// | Options   : RD_MARKER_EN adds data_out_sol / data_out_eol                |
// | Revision  : 1.0 - initial release                                        |
// +--------------------------------------------------------------------------+
interface rd_ctrl_transpose_if #(
  parameter int ADDR_WIDTH = 18,
  parameter int DATA_WIDTH = 32
);
  logic                  rd_command;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_out_valid;
  logic                  data_out_ready;
  logic                  rd_busy;
  logic                  rd_finish;
`ifdef RD_MARKER_EN
  logic                  data_out_sol;
  logic                  data_out_eol;

  modport master (
    input  rd_command, rd_data, data_out_ready,
    output rd_en, rd_addr, data_out, data_out_valid, rd_busy, rd_finish,
           data_out_sol, data_out_eol
  );
  modport slave (
    output rd_command, rd_data, data_out_ready,
    input  rd_en, rd_addr, data_out, data_out_valid, rd_busy, rd_finish,
           data_out_sol, data_out_eol
  );
`else
  modport master (
    input  rd_command, rd_data, data_out_ready,
    output rd_en, rd_addr, data_out, data_out_valid, rd_busy, rd_finish
  );
  modport slave (
    output rd_command, rd_data, data_out_ready,
    input  rd_en, rd_addr, data_out, data_out_valid, rd_busy, rd_finish
  );
`endif
endinterface
`default_nettype wire

// File: rtl/rd_ctrl_transpose.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : rd_ctrl_transpose                                             |
// | Purpose  : Reads a row-major frame (addr = r*CLO + c) back column-major, |
// |            hides the RAM read latency behind a small credit-controlled   |
// |            FIFO and streams words out over valid/ready.                  |
// | Ports    : clk, rst_n (async, active-low)                                |
// |            bus.master : rd_command in, rd_en/rd_addr out, rd_data in,    |
// |                         data_out/data_out_valid out, data_out_ready in,  |
// |                         rd_busy/rd_finish out                            |
// | Options  : RD_MARKER_EN - adds data_out_sol/data_out_eol line markers    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module rd_ctrl_transpose #(
  parameter int ADDR_WIDTH = 18,
  parameter int DATA_WIDTH = 32,
  parameter int ROW        = 64,
  parameter int CLO        = 2400,
  parameter int RD_LAT     = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  rd_ctrl_transpose_if.master bus
);

  localparam int c_DEPTH = RD_LAT + 1;
  localparam int c_PTR_W = $clog2(c_DEPTH);
  localparam int c_CNT_W = $clog2(c_DEPTH + 1);
  localparam int c_ROW_W = (ROW > 1) ? $clog2(ROW) : 1;
  localparam int c_COL_W = (CLO > 1) ? $clog2(CLO) : 1;
`ifdef RD_MARKER_EN
  localparam int c_FIFO_W = DATA_WIDTH + 2;
`else
  localparam int c_FIFO_W = DATA_WIDTH;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [c_ROW_W-1:0]    row_q, row_d;
  logic [c_COL_W-1:0]    col_q, col_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [c_CNT_W-1:0]    cred_q, cred_d;
  logic                  finish_q, finish_d;

  logic [c_FIFO_W-1:0]   mem_q [c_DEPTH];
  logic [c_PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [c_CNT_W-1:0]    fill_q;
  logic [RD_LAT-1:0]     inflight_q;

  logic                  w_push, w_pop, w_rd_en, w_last;
  logic [c_FIFO_W-1:0]   w_push_word, w_head;

  function automatic logic [c_PTR_W-1:0] ptr_inc(input logic [c_PTR_W-1:0] p);
    return (p == c_PTR_W'(c_DEPTH - 1)) ? '0 : p + c_PTR_W'(1);
  endfunction

  assign w_head = mem_q[rd_ptr_q];
  assign w_pop  = (fill_q != '0) && bus.data_out_ready;
  assign w_push = inflight_q[RD_LAT-1];
  assign w_last = (row_q == c_ROW_W'(ROW - 1)) && (col_q == c_COL_W'(CLO - 1));

  // cred_q counts words owned by this block (in flight + in FIFO). A word
  // leaving this cycle frees its slot immediately, which is what allows one
  // read per cycle with ready held high.
  assign w_rd_en = (state_q == S_READ) && ((cred_q < c_CNT_W'(c_DEPTH)) || w_pop);
  assign cred_d  = cred_q + c_CNT_W'(w_rd_en) - c_CNT_W'(w_pop);

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    col_d    = col_q;
    addr_d   = addr_q;
    finish_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.rd_command) begin
          state_d = S_READ;
          row_d   = '0;
          col_d   = '0;
          addr_d  = '0;
        end
      end
      S_READ: begin
        if (w_rd_en) begin
          if (w_last) begin
            state_d = S_DRAIN;
            row_d   = '0;
            col_d   = '0;
            addr_d  = '0;
          end else if (row_q != c_ROW_W'(ROW - 1)) begin
            // next row of the same column: step one full row forward
            addr_d = addr_q + ADDR_WIDTH'(CLO);
            row_d  = row_q + c_ROW_W'(1);
          end else begin
            // wrap to the top of the next column
            addr_d = ADDR_WIDTH'(col_q) + ADDR_WIDTH'(1);
            row_d  = '0;
            col_d  = col_q + c_COL_W'(1);
          end
        end
      end
      S_DRAIN: begin
        // leave as the last beat transfers so rd_finish lands on the next cycle
        if (cred_d == '0) begin
          state_d  = S_IDLE;
          finish_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      row_q    <= '0;
      col_q    <= '0;
      addr_q   <= '0;
      cred_q   <= '0;
      finish_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      col_q    <= col_d;
      addr_q   <= addr_d;
      cred_q   <= cred_d;
      finish_q <= finish_d;
    end
  end

  // Tag shift register: bit RD_LAT-1 is high when rd_data carries our word.
  if (RD_LAT == 1) begin : g_lat1
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) inflight_q <= '0;
      else        inflight_q <= w_rd_en;
    end
  end else begin : g_latn
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) inflight_q <= '0;
      else        inflight_q <= {inflight_q[RD_LAT-2:0], w_rd_en};
    end
  end

`ifdef RD_MARKER_EN
  // Words return in issue order, so a row counter on the push side is enough
  // to know where each word sits within its output line.
  logic [c_ROW_W-1:0] push_row_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      push_row_q <= '0;
    end else if (w_push) begin
      push_row_q <= (push_row_q == c_ROW_W'(ROW - 1)) ? '0 : push_row_q + c_ROW_W'(1);
    end
  end

  assign w_push_word      = {push_row_q == '0, push_row_q == c_ROW_W'(ROW - 1), bus.rd_data};
  assign bus.data_out_sol = w_head[DATA_WIDTH+1];
  assign bus.data_out_eol = w_head[DATA_WIDTH];
`else
  assign w_push_word = bus.rd_data;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < c_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      if (w_push) begin
        mem_q[wr_ptr_q] <= w_push_word;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (w_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      fill_q <= fill_q + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
    end
  end

  assign bus.rd_en          = w_rd_en;
  assign bus.rd_addr        = addr_q;
  assign bus.data_out       = w_head[DATA_WIDTH-1:0];
  assign bus.data_out_valid = (fill_q != '0);
  assign bus.rd_busy        = (state_q != S_IDLE);
  assign bus.rd_finish      = finish_q;

endmodule
`default_nettype wire
